// File: rtl/phys_reg_ready_table.sv
// Per-physical-register ready scoreboard: RSR/load tags set entries, dispatch
// allocations clear them. Optional macro READY_BYPASS_EN forwards same-cycle broadcasts to lookups.
`ifndef SIZE_PHYSICAL_TABLE
`define SIZE_PHYSICAL_TABLE 40
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package phys_reg_pkg;
  localparam int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG;

  typedef struct packed {
    logic                         valid;
    logic [SIZE_PHYSICAL_LOG-1:0] reg_id;
  } phys_reg;
endpackage

module phys_reg_ready_table
  import phys_reg_pkg::*;
#(
  parameter int SIZE_PHYSICAL_TABLE = `SIZE_PHYSICAL_TABLE,
  parameter int ISSUE_WIDTH         = `ISSUE_WIDTH,
  parameter int LOAD_PORTS          = 1,
  parameter int DISPATCH_WIDTH      = `DISPATCH_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recoverFlag_i,
  input  phys_reg                      rsrTag_i     [ISSUE_WIDTH],
  input  phys_reg                      loadTag_i    [LOAD_PORTS],
  input  phys_reg                      allocDest_i  [DISPATCH_WIDTH],
  input  logic [SIZE_PHYSICAL_LOG-1:0] srcLookup_i  [2*DISPATCH_WIDTH],
  output logic                         srcReady_o   [2*DISPATCH_WIDTH],
  output logic [SIZE_PHYSICAL_LOG:0]   readyCount_o
);

  localparam int LOG  = SIZE_PHYSICAL_LOG;
  localparam int NSRC = 2 * DISPATCH_WIDTH;
  localparam logic [LOG:0] SIZE_W = (LOG+1)'(SIZE_PHYSICAL_TABLE);

  logic [SIZE_PHYSICAL_TABLE-1:0] ready_q;
  logic [SIZE_PHYSICAL_TABLE-1:0] ready_d;
  logic [SIZE_PHYSICAL_TABLE-1:0] clr_vec;
  logic [SIZE_PHYSICAL_TABLE-1:0] set_vec;
  logic [LOG:0]                   count_q;
  logic [LOG:0]                   count_d;

  function automatic logic in_range(input logic [LOG-1:0] id);
    return {1'b0, id} < SIZE_W;
  endfunction

  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (allocDest_i[k].valid && in_range(allocDest_i[k].reg_id))
        clr_vec[allocDest_i[k].reg_id] = 1'b1;
    end
  end

  always_comb begin
    set_vec = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      if (rsrTag_i[l].valid && in_range(rsrTag_i[l].reg_id))
        set_vec[rsrTag_i[l].reg_id] = 1'b1;
    end
    for (int p = 0; p < LOAD_PORTS; p++) begin
      if (loadTag_i[p].valid && in_range(loadTag_i[p].reg_id))
        set_vec[loadTag_i[p].reg_id] = 1'b1;
    end
  end

  // Clear beats set so a late tag for a just-recycled register is dropped.
  always_comb begin
    if (recoverFlag_i) ready_d = '1;
    else               ready_d = (ready_q | set_vec) & ~clr_vec;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < SIZE_PHYSICAL_TABLE; i++)
      count_d = count_d + (LOG+1)'(ready_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= '1;
      count_q <= SIZE_W;
    end else begin
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  assign readyCount_o = count_q;

  // Same-cycle allocations are intentionally invisible to lookups.
  always_comb begin
    for (int j = 0; j < NSRC; j++) begin
      srcReady_o[j] = 1'b0;
      if (in_range(srcLookup_i[j])) begin
        srcReady_o[j] = ready_q[srcLookup_i[j]];
`ifdef READY_BYPASS_EN
        if (!recoverFlag_i) begin
          for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (rsrTag_i[l].valid && rsrTag_i[l].reg_id == srcLookup_i[j])
              srcReady_o[j] = 1'b1;
          end
          for (int p = 0; p < LOAD_PORTS; p++) begin
            if (loadTag_i[p].valid && loadTag_i[p].reg_id == srcLookup_i[j])
              srcReady_o[j] = 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Bench for phys_reg_ready_table: directed scenarios plus randomized traffic
// checked against a set/clear reference model of the ready table.
module tb_phys_reg_ready_table;
  import phys_reg_pkg::*;

  localparam int N    = `SIZE_PHYSICAL_TABLE;
  localparam int IW   = `ISSUE_WIDTH;
  localparam int LP   = 1;
  localparam int DW   = `DISPATCH_WIDTH;
  localparam int NSRC = 2 * DW;
  localparam int LOG  = SIZE_PHYSICAL_LOG;

  logic               clk = 1'b0;
  logic               reset;
  logic               recoverFlag_i;
  phys_reg            rsrTag_i    [IW];
  phys_reg            loadTag_i   [LP];
  phys_reg            allocDest_i [DW];
  logic [LOG-1:0]     srcLookup_i [NSRC];
  logic               srcReady_o  [NSRC];
  logic [LOG:0]       readyCount_o;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mdl [N];
  int  prev_cnt;

  phys_reg_ready_table #(
    .SIZE_PHYSICAL_TABLE(N), .ISSUE_WIDTH(IW), .LOAD_PORTS(LP), .DISPATCH_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .rsrTag_i(rsrTag_i), .loadTag_i(loadTag_i), .allocDest_i(allocDest_i),
    .srcLookup_i(srcLookup_i), .srcReady_o(srcReady_o), .readyCount_o(readyCount_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    recoverFlag_i = 1'b0;
    for (int l = 0; l < IW; l++) rsrTag_i[l] = '0;
    for (int p = 0; p < LP; p++) loadTag_i[p] = '0;
    for (int k = 0; k < DW; k++) allocDest_i[k] = '0;
    for (int j = 0; j < NSRC; j++) srcLookup_i[j] = '0;
  endtask

  function automatic bit mdl_lookup(input int id);
    bit r;
    if (id >= N) return 1'b0;
    r = mdl[id];
`ifdef READY_BYPASS_EN
    if (!recoverFlag_i) begin
      for (int l = 0; l < IW; l++) if (rsrTag_i[l].valid && int'(rsrTag_i[l].reg_id) == id) r = 1'b1;
      for (int p = 0; p < LP; p++) if (loadTag_i[p].valid && int'(loadTag_i[p].reg_id) == id) r = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic int mdl_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mdl[i]);
    return c;
  endfunction

  task automatic model_edge();
    bit clr [N];
    if (reset || recoverFlag_i) begin
      for (int i = 0; i < N; i++) mdl[i] = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) clr[i] = 1'b0;
    for (int k = 0; k < DW; k++)
      if (allocDest_i[k].valid && int'(allocDest_i[k].reg_id) < N) clr[allocDest_i[k].reg_id] = 1'b1;
    for (int l = 0; l < IW; l++)
      if (rsrTag_i[l].valid && int'(rsrTag_i[l].reg_id) < N) mdl[rsrTag_i[l].reg_id] = 1'b1;
    for (int p = 0; p < LP; p++)
      if (loadTag_i[p].valid && int'(loadTag_i[p].reg_id) < N) mdl[loadTag_i[p].reg_id] = 1'b1;
    for (int i = 0; i < N; i++) if (clr[i]) mdl[i] = 1'b0;
  endtask

  // One cycle: check lookups against the model, clock, update model, check count.
  task automatic tick();
    #1;
    if (!reset)
      for (int j = 0; j < NSRC; j++)
        check($sformatf("lookup[%0d] id=%0d", j, srcLookup_i[j]), 32'(srcReady_o[j]),
              32'(mdl_lookup(int'(srcLookup_i[j]))));
    @(posedge clk);
    model_edge();
    #1;
    check("ready_count", 32'(readyCount_o), 32'(mdl_count()));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    srcLookup_i[0] = 6'd0; srcLookup_i[1] = 6'd5; srcLookup_i[2] = 6'(N-1);
    #1;
    check("rst_id0", 32'(srcReady_o[0]), 32'd1);
    check("rst_id5", 32'(srcReady_o[1]), 32'd1);
    check("rst_idmax", 32'(srcReady_o[2]), 32'd1);
    check("rst_count", 32'(readyCount_o), 32'(N));
    tick();

    // Allocate reg 12: old value visible in the alloc cycle, cleared next cycle
    idle_inputs();
    allocDest_i[1] = '{valid: 1'b1, reg_id: 6'd12};
    srcLookup_i[0] = 6'd12;
    #1 check("alloc12_same", 32'(srcReady_o[0]), 32'd1);
    tick();
    idle_inputs();
    srcLookup_i[0] = 6'd12;
    #1 check("alloc12_next", 32'(srcReady_o[0]), 32'd0);
    check("alloc12_count", 32'(readyCount_o), 32'(N-1));
    tick();

    // Broadcast reg 12 on lane 2
    idle_inputs();
    rsrTag_i[2] = '{valid: 1'b1, reg_id: 6'd12};
    srcLookup_i[0] = 6'd12;
`ifdef READY_BYPASS_EN
    #1 check("bcast12_same", 32'(srcReady_o[0]), 32'd1);
`else
    #1 check("bcast12_same", 32'(srcReady_o[0]), 32'd0);
`endif
    tick();
    idle_inputs();
    srcLookup_i[0] = 6'd12;
    #1 check("bcast12_next", 32'(srcReady_o[0]), 32'd1);
    tick();

    // Alloc and load tag on reg 20 together: clear wins
    idle_inputs();
    prev_cnt = int'(readyCount_o);
    allocDest_i[0] = '{valid: 1'b1, reg_id: 6'd20};
    loadTag_i[0]   = '{valid: 1'b1, reg_id: 6'd20};
    tick();
    idle_inputs();
    srcLookup_i[0] = 6'd20;
    #1 check("clrwin20", 32'(srcReady_o[0]), 32'd0);
    check("clrwin20_count", 32'(readyCount_o), 32'(prev_cnt-1));
    tick();

    // Clear 3,7,9 then recover alongside an alloc of reg 4
    idle_inputs();
    allocDest_i[0] = '{valid: 1'b1, reg_id: 6'd3};
    allocDest_i[1] = '{valid: 1'b1, reg_id: 6'd7};
    allocDest_i[2] = '{valid: 1'b1, reg_id: 6'd9};
    tick();
    idle_inputs();
    recoverFlag_i  = 1'b1;
    allocDest_i[0] = '{valid: 1'b1, reg_id: 6'd4};
    tick();
    idle_inputs();
    srcLookup_i[0] = 6'd3; srcLookup_i[1] = 6'd7; srcLookup_i[2] = 6'd9; srcLookup_i[3] = 6'd4;
    #1;
    for (int j = 0; j < 4; j++) check($sformatf("recover_id%0d", srcLookup_i[j]), 32'(srcReady_o[j]), 32'd1);
    check("recover_count", 32'(readyCount_o), 32'(N));
    tick();

    // Two lanes broadcast reg 30 after it is cleared
    idle_inputs();
    allocDest_i[3] = '{valid: 1'b1, reg_id: 6'd30};
    tick();
    idle_inputs();
    prev_cnt = int'(readyCount_o);
    rsrTag_i[0] = '{valid: 1'b1, reg_id: 6'd30};
    rsrTag_i[1] = '{valid: 1'b1, reg_id: 6'd30};
    tick();
    idle_inputs();
    srcLookup_i[0] = 6'd30;
    #1 check("dup30", 32'(srcReady_o[0]), 32'd1);
    check("dup30_count", 32'(readyCount_o), 32'(prev_cnt+1));
    tick();

    // Out-of-range lookup
    idle_inputs();
    srcLookup_i[0] = 6'(N + 3);
    #1 check("oor_lookup", 32'(srcReady_o[0]), 32'd0);
    tick();

    // Randomized traffic, ids spanning beyond the table
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      recoverFlag_i = ($urandom_range(0, 24) == 0);
      for (int l = 0; l < IW; l++)
        rsrTag_i[l] = '{valid: 1'($urandom_range(0, 1)), reg_id: 6'($urandom_range(0, N + 7))};
      for (int p = 0; p < LP; p++)
        loadTag_i[p] = '{valid: 1'($urandom_range(0, 1)), reg_id: 6'($urandom_range(0, N + 7))};
      for (int k = 0; k < DW; k++)
        allocDest_i[k] = '{valid: ($urandom_range(0, 2) != 0), reg_id: 6'($urandom_range(0, N + 7))};
      for (int j = 0; j < NSRC; j++) begin
        if ($urandom_range(0, 1) == 1 && IW > 0 && j < IW)
          srcLookup_i[j] = rsrTag_i[j].reg_id;
        else
          srcLookup_i[j] = 6'($urandom_range(0, N + 7));
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/phys_reg_ready_table.md
# phys_reg_ready_table

Per-physical-register ready scoreboard in the issue stage, directly downstream of the per-lane RSR shift registers. It consumes each lane's delayed bypass tag and the load writeback tags, and sets the matching ready bits. Dispatch allocations clear those bits. Dispatch reads the table to seed the source-ready flags of instructions entering the issue queue.

## Interface
Parameters:
- SIZE_PHYSICAL_TABLE, `SIZE_PHYSICAL_TABLE: number of physical registers (entries).
- ISSUE_WIDTH, `ISSUE_WIDTH: number of RSR broadcast ports, one per lane.
- LOAD_PORTS, 1: number of load writeback tag ports from the LSU.
- DISPATCH_WIDTH, `DISPATCH_WIDTH: instructions dispatched per cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- recoverFlag_i  in  1  pipeline flush; sets every entry ready.
- rsrTag_i[ISSUE_WIDTH]  in  phys_reg  per-lane RSR tag (valid, reg_id).
- loadTag_i[LOAD_PORTS]  in  phys_reg  load writeback tag.
- allocDest_i[DISPATCH_WIDTH]  in  phys_reg  newly renamed destinations; valid entries clear their ready bit.
- srcLookup_i[2*DISPATCH_WIDTH]  in  `SIZE_PHYSICAL_LOG  source register ids of dispatching instructions.
- srcReady_o[2*DISPATCH_WIDTH]  out  1  ready flag per looked-up source.
- readyCount_o  out  `SIZE_PHYSICAL_LOG+1  population count of ready entries, registered.

## Operation
- State: ready vector READY[SIZE_PHYSICAL_TABLE-1:0] and a registered readyCount_o.
- Per-cycle next-state priority, highest first:
  - reset: all READY = 1; readyCount_o = SIZE_PHYSICAL_TABLE.
  - recoverFlag_i: all READY = 1. All in-flight producers are squashed, so surviving mappings are committed. Same-cycle tags and allocations are ignored.
  - Clear: each valid allocDest_i[k] clears READY[reg_id].
  - Set: each valid rsrTag_i or loadTag_i sets READY[reg_id], unless that reg_id is also cleared this cycle. Clear wins, so a stale tag for a recycled register is dropped.
- Duplicate set tags to one entry in the same cycle are legal and idempotent. Duplicate clears are legal.
- Invalid tags and allocations have no effect regardless of reg_id.
- Lookup reads the current-cycle READY value combinationally.
  - Same-cycle allocDest_i clears are not visible to the lookup. Intra-group dependencies are resolved by rename, not here.
  - With bypass enabled, same-cycle broadcast matches are visible (see Configuration).
- readyCount_o is recomputed from the next-state vector, so it always equals popcount(READY) one cycle after any update.
- Out-of-range reg_id (≥ SIZE_PHYSICAL_TABLE) is ignored for both set and clear. Lookup of an out-of-range id returns 0.

## Timing
- Set/clear latency: 1 cycle. An update at edge N is visible on srcReady_o in the cycle after edge N.
- srcReady_o is combinational from srcLookup_i, READY and, when enabled, the bypass path. It has no registered stage.
- After reset deasserts:
  - srcReady_o is 1 for every in-range id.
  - readyCount_o = SIZE_PHYSICAL_TABLE.
- recoverFlag_i asserted in cycle N:
  - Every entry reads ready from cycle N+1.
  - An allocation in cycle N is discarded.
- Reset asserted mid-operation overrides recoverFlag_i and all ports within the same edge.

## Configuration
- READY_BYPASS_EN defined:
  - srcReady_o[j] = READY[id] OR (any valid rsrTag_i or loadTag_i with reg_id == id in the same cycle).
  - A consumer dispatched in the broadcast cycle sees the source as ready.
  - The bypass term is suppressed while recoverFlag_i is high.
- READY_BYPASS_EN undefined:
  - srcReady_o[j] = READY[id] only.
  - Dispatch logic must capture same-cycle broadcasts itself.
  - Table next-state behaviour is unchanged.

## Test plan
- Reset, then lookup ids 0, 5, SIZE_PHYSICAL_TABLE-1 -> srcReady_o all 1; readyCount_o = SIZE_PHYSICAL_TABLE.
- Allocate reg 12 in cycle 1 and look up 12 in cycles 1 and 2 -> cycle 1 reads 1, cycle 2 reads 0; readyCount_o drops by 1 in cycle 2.
- Broadcast rsrTag_i[2] = {1, 12} in cycle 3 and look up 12 in cycle 3 -> 1 with READY_BYPASS_EN, 0 without; cycle 4 reads 1 in both builds.
- Allocate reg 20 and broadcast loadTag_i = {1, 20} in the same cycle -> reg 20 reads 0 next cycle; readyCount_o decrements by exactly 1.
- Clear regs 3, 7, 9; assert recoverFlag_i with a simultaneous allocation of reg 4 -> next cycle all four read 1; readyCount_o = SIZE_PHYSICAL_TABLE.
- Two lanes broadcast reg 30 in one cycle after reg 30 is cleared -> reg 30 reads 1; readyCount_o increments by exactly 1.
